// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM controller arbiter.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam int unsigned PORT_MEM    = 0;
  localparam int unsigned PORT_IF     = 1;
  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned LINE_W      = 64;
  localparam int unsigned WORD_W      = 32;

  // Winner among pending ports; on a tie round-robin favours the port not granted last.
  function automatic logic arb_pick(input logic pend0, input logic pend1,
                                    input logic round_robin, input logic last_grant);
    if (pend0 && pend1) return round_robin ? ~last_grant : 1'b0;
    return pend1;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and controller signal bundle for sram_arbiter.
interface sram_arbiter_if;
  import sram_arbiter_pkg::*;

  logic                   req0_r_en, req0_w_en;
  logic [SRAM_ADDR_W-1:0] req0_addr;
  logic [WORD_W-1:0]      req0_wdata;
  logic [LINE_W-1:0]      req0_rdata;
  logic                   req0_ready, req0_stall;

  logic                   req1_r_en, req1_w_en;
  logic [SRAM_ADDR_W-1:0] req1_addr;
  logic [WORD_W-1:0]      req1_wdata;
  logic [LINE_W-1:0]      req1_rdata;
  logic                   req1_ready, req1_stall;

  logic [1:0]             bus_err;

  logic [SRAM_ADDR_W-1:0] ctrl_addr;
  logic [WORD_W-1:0]      ctrl_wdata;
  logic                   ctrl_r_en, ctrl_w_en;
  logic [LINE_W-1:0]      ctrl_rdata;
  logic                   ctrl_freeze;

  modport slave (
    input  req0_r_en, req0_w_en, req0_addr, req0_wdata,
    input  req1_r_en, req1_w_en, req1_addr, req1_wdata,
    input  ctrl_rdata, ctrl_freeze,
    output req0_rdata, req0_ready, req0_stall,
    output req1_rdata, req1_ready, req1_stall,
    output bus_err, ctrl_addr, ctrl_wdata, ctrl_r_en, ctrl_w_en
  );

  modport master (
    output req0_r_en, req0_w_en, req0_addr, req0_wdata,
    output req1_r_en, req1_w_en, req1_addr, req1_wdata,
    output ctrl_rdata, ctrl_freeze,
    input  req0_rdata, req0_ready, req0_stall,
    input  req1_rdata, req1_ready, req1_stall,
    input  bus_err, ctrl_addr, ctrl_wdata, ctrl_r_en, ctrl_w_en
  );

endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single SRAM controller: grant, hold stable
// until freeze drops, return the line, then one idle cycle before the next grant.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter bit          ROUND_ROBIN = 1'b0,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned TW          = 5
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);

  arb_state_e             state_q, state_d;
  logic                   grant_q, grant_d;
  logic                   last_q, last_d;
  logic                   write_q, write_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0]      wdata_q, wdata_d;
  logic [LINE_W-1:0]      rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0]             err_q, err_d;
  logic [TW-1:0]          wd_q, wd_d;

  logic pend0, pend1, pick, busy, rel;

  assign pend0 = bus.req0_r_en | bus.req0_w_en;
  assign pend1 = bus.req1_r_en | bus.req1_w_en;
  assign pick  = arb_pick(pend0, pend1, ROUND_ROBIN, last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err_q    <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    err_d    = err_q;
    wd_d     = '0;
    unique case (state_q)
      IDLE: begin
        if (pend0 || pend1) begin
          grant_d = pick;
          last_d  = pick;
          addr_d  = pick ? bus.req1_addr  : bus.req0_addr;
          wdata_d = pick ? bus.req1_wdata : bus.req0_wdata;
          write_d = pick ? bus.req1_w_en  : bus.req0_w_en;
          state_d = BUSY;
        end
      end
      BUSY: begin
        wd_d = wd_q + TW'(1);
        if (!bus.ctrl_freeze) begin
          if (!write_q) begin
            if (grant_q) rdata1_d = bus.ctrl_rdata;
            else         rdata0_d = bus.ctrl_rdata;
          end
          state_d = RELEASE;
        end else if (wd_q == TW'(TIMEOUT - 1)) begin
          // Abort: complete the handshake so the requester unfreezes, flag it sticky.
          err_d[grant_q] = 1'b1;
          state_d        = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == BUSY);
  assign rel  = (state_q == RELEASE);

  assign bus.ctrl_addr  = busy ? addr_q  : '0;
  assign bus.ctrl_wdata = busy ? wdata_q : '0;
  assign bus.ctrl_r_en  = busy & ~write_q;
  assign bus.ctrl_w_en  = busy &  write_q;

  assign bus.req0_ready = rel & (grant_q == 1'(PORT_MEM));
  assign bus.req1_ready = rel & (grant_q == 1'(PORT_IF));
  assign bus.req0_rdata = rdata0_q;
  assign bus.req1_rdata = rdata1_q;
  assign bus.req0_stall = pend0 & ~bus.req0_ready;
  assign bus.req1_stall = pend1 & ~bus.req1_ready;
  assign bus.bus_err    = err_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: fixed-priority and round-robin instances share stimulus,
// each with its own 4-beat controller model; completions are scoreboarded.
module tb_sram_arbiter;

  typedef struct {
    int          port;
    bit          chk;
    logic [63:0] data;
  } exp_t;

  typedef struct {
    int          port;
    logic        r;
    logic        w;
    logic [17:0] addr;
    logic [31:0] wdata;
    bit          wd;
    int          lat;
    bit          chk;
    logic [63:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hang = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  int          beat0 = 0;
  int          beat1 = 0;
  logic [17:0] cap_addr0 = '0;
  logic [31:0] cap_wdata0 = '0;
  logic        cap_w0 = 1'b0;

  always #5 clk = ~clk;

  sram_arbiter_if u_if0 ();
  sram_arbiter_if u_if1 ();

  sram_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(16), .TW(5)) u_dut0 (.clk(clk), .rst(rst), .bus(u_if0));
  sram_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(16), .TW(5)) u_dut1 (.clk(clk), .rst(rst), .bus(u_if1));

  assign u_if1.req0_r_en  = u_if0.req0_r_en;
  assign u_if1.req0_w_en  = u_if0.req0_w_en;
  assign u_if1.req0_addr  = u_if0.req0_addr;
  assign u_if1.req0_wdata = u_if0.req0_wdata;
  assign u_if1.req1_r_en  = u_if0.req1_r_en;
  assign u_if1.req1_w_en  = u_if0.req1_w_en;
  assign u_if1.req1_addr  = u_if0.req1_addr;
  assign u_if1.req1_wdata = u_if0.req1_wdata;

  function automatic logic [63:0] line_of(input logic [17:0] a);
    if (a == 18'h00010) return 64'h0123_4567_89AB_CDEF;
    return {14'h2A5, a, 14'h155, ~a};
  endfunction

  // Controller model: freeze drops on the 4th consecutive enabled beat.
  assign u_if0.ctrl_freeze = (u_if0.ctrl_r_en | u_if0.ctrl_w_en) & (hang | (beat0 != 3));
  assign u_if1.ctrl_freeze = (u_if1.ctrl_r_en | u_if1.ctrl_w_en) & (hang | (beat1 != 3));
  assign u_if0.ctrl_rdata  = line_of(u_if0.ctrl_addr);
  assign u_if1.ctrl_rdata  = line_of(u_if1.ctrl_addr);

  always @(posedge clk) begin
    beat0 <= (u_if0.ctrl_r_en | u_if0.ctrl_w_en) ? beat0 + 1 : 0;
    beat1 <= (u_if1.ctrl_r_en | u_if1.ctrl_w_en) ? beat1 + 1 : 0;
    if ((u_if0.ctrl_r_en | u_if0.ctrl_w_en) && !u_if0.ctrl_freeze) begin
      cap_addr0  <= u_if0.ctrl_addr;
      cap_wdata0 <= u_if0.ctrl_wdata;
      cap_w0     <= u_if0.ctrl_w_en;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input int d, input int port, input logic [63:0] rd);
    exp_t e;
    if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb%0d_unexpected: ready on port %0d, expected none (t=%0t)", d, port, $time);
      return;
    end
    e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
    chk($sformatf("sb%0d_port", d), 64'(port), 64'(e.port));
    if (e.chk) chk($sformatf("sb%0d_rdata", d), rd, e.data);
  endtask

  always @(negedge clk) begin
    if (u_if0.req0_ready) sb_pop(0, 0, u_if0.req0_rdata);
    if (u_if0.req1_ready) sb_pop(0, 1, u_if0.req1_rdata);
    if (u_if1.req0_ready) sb_pop(1, 0, u_if1.req0_rdata);
    if (u_if1.req1_ready) sb_pop(1, 1, u_if1.req1_rdata);
  end

  task automatic push_both(input int port, input bit c, input logic [63:0] d);
    exp_t e;
    e.port = port;
    e.chk  = c;
    e.data = d;
    sb0.push_back(e);
    sb1.push_back(e);
  endtask

  task automatic clear_reqs();
    u_if0.req0_r_en = 1'b0; u_if0.req0_w_en = 1'b0; u_if0.req0_addr = '0; u_if0.req0_wdata = '0;
    u_if0.req1_r_en = 1'b0; u_if0.req1_w_en = 1'b0; u_if0.req1_addr = '0; u_if0.req1_wdata = '0;
  endtask

  task automatic drive_port(input int p, input logic r, input logic w,
                            input logic [17:0] a, input logic [31:0] d);
    if (p == 0) begin
      u_if0.req0_r_en = r; u_if0.req0_w_en = w; u_if0.req0_addr = a; u_if0.req0_wdata = d;
    end else begin
      u_if0.req1_r_en = r; u_if0.req1_w_en = w; u_if0.req1_addr = a; u_if0.req1_wdata = d;
    end
  endtask

  function automatic logic rdy0(input int p);
    return (p == 0) ? u_if0.req0_ready : u_if0.req1_ready;
  endfunction

  function automatic logic stl0(input int p);
    return (p == 0) ? u_if0.req0_stall : u_if0.req1_stall;
  endfunction

  task automatic reset_all();
    clear_reqs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Drives one transaction visible from the current cycle (cycle 0) and checks it cycle by cycle.
  task automatic do_txn(input vec_t v);
    int lat;
    bit got;
    clear_reqs();
    drive_port(v.port, v.r, v.w, v.addr, v.wdata);
    push_both(v.port, v.chk, v.exp_rdata);
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      if (rdy0(v.port)) got = 1;
      else begin
        chk("stall_pending", 64'(stl0(v.port)), 64'(!(v.wd && lat >= 2)));
        chk("ctrl_en", 64'({u_if0.ctrl_r_en, u_if0.ctrl_w_en}),
            (lat == 0) ? 64'd0 : (v.w ? 64'd1 : 64'd2));
        if (v.wd && lat == 1) begin
          clear_reqs();
          u_if0.req0_addr = 18'h00099;
          u_if0.req1_addr = 18'h00099;
        end
        lat++;
      end
    end
    chk("latency", 64'(lat), 64'(v.lat));
    if (got) begin
      chk("stall_at_ready", 64'(stl0(v.port)), 64'd0);
      chk("release_en", 64'({u_if0.ctrl_r_en, u_if0.ctrl_w_en}), 64'd0);
      if (v.lat == 5) begin
        chk("ctrl_addr_seen", 64'(cap_addr0), 64'(v.addr));
        chk("ctrl_op_seen", 64'(cap_w0), 64'(v.w));
        if (v.w) chk("ctrl_wdata_seen", 64'(cap_wdata0), 64'(v.wdata));
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[7];
  vec_t v;
  int   r0c, r1c;

  initial begin
    vecs[0] = '{0, 1'b1, 1'b0, 18'h00010, 32'h0,         1'b0, 5, 1'b1, 64'h0123_4567_89AB_CDEF};
    vecs[1] = '{0, 1'b0, 1'b1, 18'h00040, 32'h1234_5678, 1'b0, 5, 1'b0, 64'h0};
    vecs[2] = '{0, 1'b1, 1'b0, 18'h00040, 32'h0,         1'b0, 5, 1'b1, line_of(18'h00040)};
    vecs[3] = '{1, 1'b1, 1'b0, 18'h3FFFF, 32'h0,         1'b0, 5, 1'b1, line_of(18'h3FFFF)};
    vecs[4] = '{1, 1'b1, 1'b1, 18'h00055, 32'hCAFE_F00D, 1'b0, 5, 1'b0, 64'h0};
    vecs[5] = '{0, 1'b0, 1'b1, 18'h00000, 32'hFFFF_FFFF, 1'b0, 5, 1'b0, 64'h0};
    vecs[6] = '{0, 1'b1, 1'b0, 18'h00077, 32'h0,         1'b1, 5, 1'b1, line_of(18'h00077)};

    reset_all();
    chk("rst_ctrl_addr", 64'(u_if0.ctrl_addr), 64'd0);
    chk("rst_ctrl_wdata", 64'(u_if0.ctrl_wdata), 64'd0);
    chk("rst_ctrl_en", 64'({u_if0.ctrl_r_en, u_if0.ctrl_w_en}), 64'd0);
    chk("rst_ready", 64'({u_if0.req0_ready, u_if0.req1_ready, u_if1.req0_ready, u_if1.req1_ready}), 64'd0);
    chk("rst_rdata0", u_if0.req0_rdata, 64'd0);
    chk("rst_rdata1", u_if0.req1_rdata, 64'd0);
    chk("rst_bus_err", 64'({u_if0.bus_err, u_if1.bus_err}), 64'd0);
    chk("rst_stall", 64'({u_if0.req0_stall, u_if0.req1_stall}), 64'd0);

    for (int i = 0; i < 7; i++) do_txn(vecs[i]);
    clear_reqs();
    repeat (3) @(posedge clk);
    #1;

    // Simultaneous: port 0 write and port 1 read presented together.
    reset_all();
    drive_port(0, 1'b0, 1'b1, 18'h00008, 32'hDEAD_BEEF);
    drive_port(1, 1'b1, 1'b0, 18'h00020, 32'h0);
    push_both(0, 1'b0, 64'h0);
    push_both(1, 1'b1, line_of(18'h00020));
    r0c = -1;
    r1c = -1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (u_if0.req0_ready && r0c < 0) r0c = c;
      if (u_if0.req1_ready && r1c < 0) r1c = c;
      if (c == 1) begin
        chk("sim_w_en", 64'(u_if0.ctrl_w_en), 64'd1);
        chk("sim_w_addr", 64'(u_if0.ctrl_addr), 64'h8);
        chk("sim_w_data", 64'(u_if0.ctrl_wdata), 64'hDEAD_BEEF);
      end
      if (c == 5) chk("sim_stall1", 64'(u_if0.req1_stall), 64'd1);
      if (c == 6) chk("sim_idle_gap", 64'({u_if0.ctrl_r_en, u_if0.ctrl_w_en}), 64'd0);
      if (c == 7) chk("sim_r_addr", 64'({u_if0.ctrl_r_en, u_if0.ctrl_addr}), {45'd1, 18'h00020});
      @(posedge clk);
      #1;
      if (r0c == c) u_if0.req0_w_en = 1'b0;
      if (r1c == c) u_if0.req1_r_en = 1'b0;
    end
    chk("sim_ready0_cycle", 64'(r0c), 64'd5);
    chk("sim_ready1_cycle", 64'(r1c), 64'd11);

    // Both ports held continuously for four transactions.
    reset_all();
    drive_port(0, 1'b1, 1'b0, 18'h00100, 32'h0);
    drive_port(1, 1'b1, 1'b0, 18'h00200, 32'h0);
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.port = 0; e.chk = 1'b1; e.data = line_of(18'h00100);
      sb0.push_back(e);
      e.port = k % 2; e.data = line_of((k % 2 == 1) ? 18'h00200 : 18'h00100);
      sb1.push_back(e);
    end
    repeat (24) @(posedge clk);
    #1;
    clear_reqs();
    repeat (8) @(posedge clk);
    #1;
    chk("rr_sb0_drained", 64'(sb0.size()), 64'd0);
    chk("rr_sb1_drained", 64'(sb1.size()), 64'd0);

    // Hung controller: watchdog aborts, rdata untouched, next request still served.
    reset_all();
    hang = 1'b1;
    v = '{0, 1'b1, 1'b0, 18'h00030, 32'h0, 1'b0, 17, 1'b1, 64'h0};
    do_txn(v);
    hang = 1'b0;
    chk("wd_bus_err0", 64'(u_if0.bus_err), 64'd1);
    chk("wd_bus_err1", 64'(u_if1.bus_err), 64'd1);
    v = '{1, 1'b1, 1'b0, 18'h00031, 32'h0, 1'b0, 5, 1'b1, line_of(18'h00031)};
    do_txn(v);
    chk("wd_bus_err_sticky", 64'(u_if0.bus_err), 64'd1);

    // Reset asserted mid-BUSY drops the transaction without a ready.
    clear_reqs();
    drive_port(1, 1'b1, 1'b0, 18'h00ABC, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("midbusy_r_en_before", 64'(u_if0.ctrl_r_en), 64'd1);
    rst = 1'b1;
    #1;
    chk("midbusy_r_en_async", 64'({u_if0.ctrl_r_en, u_if1.ctrl_r_en}), 64'd0);
    chk("midbusy_addr_async", 64'(u_if0.ctrl_addr), 64'd0);
    clear_reqs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midbusy_bus_err_cleared", 64'(u_if0.bus_err), 64'd0);
    v = '{1, 1'b1, 1'b0, 18'h00ABC, 32'h0, 1'b0, 5, 1'b1, line_of(18'h00ABC)};
    do_txn(v);
    clear_reqs();
    repeat (4) @(posedge clk);
    #1;
    chk("final_sb0_drained", 64'(sb0.size()), 64'd0);
    chk("final_sb1_drained", 64'(sb1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $fatal(1);
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single SRAM controller between two requesters: port 0 = MEM stage (data), port 1 = IF stage (instruction fetch).
- Sequences each transaction: holds address, data and enables stable until the controller drops its freeze, then returns the 64-bit line.
- Inserts one idle cycle between transactions so the controller's beat counter restarts at beat 0.
- Provides per-port stall signals for pipeline freeze, plus a watchdog against a hung controller.

Parameters:
- ROUND_ROBIN, 0: 0 = fixed priority (port 0 wins); 1 = alternate on simultaneous requests.
- TIMEOUT, 16: maximum BUSY cycles before abort; must be >= 5.
- TW, 5: watchdog counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req0_r_en  in  1  port 0 read request, level, held until ready
- req0_w_en  in  1  port 0 write request, level, held until ready
- req0_addr  in  18  port 0 address
- req0_wdata  in  32  port 0 write data
- req0_rdata  out  64  port 0 read line, valid while req0_ready=1
- req0_ready  out  1  port 0 completion pulse, 1 cycle
- req0_stall  out  1  port 0 pending and not complete
- req1_r_en, req1_w_en, req1_addr, req1_wdata, req1_rdata, req1_ready, req1_stall: same as port 0
- bus_err  out  2  sticky watchdog abort flag per port
- ctrl_addr  out  18  to controller addr
- ctrl_wdata  out  32  to controller data_in
- ctrl_r_en  out  1  to controller MEM_R_en
- ctrl_w_en  out  1  to controller MEM_W_en
- ctrl_rdata  in  64  from controller data_out
- ctrl_freeze  in  1  from controller: high while transaction incomplete

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, last_grant=1, watchdog=0.
  - All ctrl_* outputs 0; all req*_ready and req*_rdata 0; bus_err=0.
  - A transaction in flight is dropped; ctrl enables fall immediately, no ready is issued.
- States: IDLE, BUSY, RELEASE. Encoding in package; registered state.
- IDLE:
  - Arbitration uses pend_i = req_i_r_en | req_i_w_en.
  - Single requester: it wins.
  - Both requesting: ROUND_ROBIN=0 -> port 0 wins; ROUND_ROBIN=1 -> port != last_grant wins.
  - On a grant: register grant, addr, wdata and op; set last_grant; go to BUSY. Write wins if r_en and w_en are both high.
- BUSY:
  - ctrl_addr and ctrl_wdata come from the latched registers, never live inputs; exactly one of ctrl_r_en/ctrl_w_en is 1.
  - watchdog increments each cycle.
  - ctrl_freeze=0 sampled: latch ctrl_rdata (reads only), go to RELEASE.
  - watchdog==TIMEOUT-1 with ctrl_freeze=1: set bus_err[grant], go to RELEASE, leave rdata unchanged.
- RELEASE (exactly 1 cycle):
  - ctrl enables 0; req_grant_ready=1; req_grant_rdata valid.
  - watchdog cleared; next state IDLE.
  - Writes also pulse ready; rdata is unchanged for writes.
- Latency and throughput:
  - Request visible in cycle 0 -> BUSY cycles 1..4 (controller needs 4 beats) -> ready in cycle 5.
  - Peak throughput: 1 transaction per 6 cycles.
- req_i_stall = pend_i & ~req_i_ready (combinational), so a pipeline stage unfreezes in the ready cycle.
- Requester drops or changes its request in the cycle after ready. A request still held in that cycle is treated as a new transaction.
- Request withdrawn while BUSY: the transaction completes using the latched values, and ready still pulses.
- The losing port's request is kept (level-held) and is served in the next IDLE; no request is lost.
- bus_err is cleared only by reset.

Decomposition:
- Shared package:
  - state encoding IDLE=2'd0, BUSY=2'd1, RELEASE=2'd2
  - port indices PORT_MEM=0, PORT_IF=1
  - SRAM_ADDR_W=18, LINE_W=64, WORD_W=32
- No sub-module. Arbitration, FSM and watchdog are inline, roughly 150-250 lines.

Test Plan:
- Single read: port 0 read addr 18'h00010, controller model returns 64'h0123_4567_89AB_CDEF after 4 beats -> req0_ready high in cycle 5 with that rdata; req0_stall high in cycles 0-4; ctrl_r_en high in cycles 1-4 only.
- Simultaneous requests, ROUND_ROBIN=0: port 0 write addr 18'h00008 data 32'hDEADBEEF and port 1 read addr 18'h00020 in cycle 0 -> port 0 ready in cycle 5, port 1 granted in cycle 6, port 1 ready in cycle 11.
- ROUND_ROBIN=1, both ports requesting continuously -> grants alternate 0,1,0,1 (first grant to port 0 after reset); no port waits more than 1 transaction.
- Watchdog, TIMEOUT=16: controller holds freeze high forever -> ready pulses after 16 BUSY cycles; bus_err=2'b01 (port 0); next request is still serviced.
- Reset mid-BUSY: assert rst in cycle 2 of a port 1 read -> ctrl_r_en=0 within the same cycle (async); no ready pulse; after release, a fresh request completes normally in 6 cycles.
- Write then read on the same port, back-to-back: ready for the write in cycle 5; read re-presented in cycle 6; read ready in cycle 11; a RELEASE cycle with ctrl enables 0 appears between the two transactions.
